// File: rtl/car_flow_counter.sv
// car_flow_counter
//   Decodes the blocking order of two debounced beam sensors into car-entered
//   and car-exited events, and keeps the lot occupancy count.
//   Ports:
//     clk        system clock, inputs sampled on posedge
//     reset      asynchronous, active-high reset
//     sensor_a   outer beam, 1 = blocked
//     sensor_b   inner beam, 1 = blocked
//     car_count  current occupancy (saturates at CAPACITY and at 0)
//     car_enter  1-cycle pulse, a car completed entry
//     car_exit   1-cycle pulse, a car completed exit
//     overflow   1-cycle pulse, entry completed while full
//     underflow  1-cycle pulse, exit completed while empty
//     full       car_count == CAPACITY
//     empty      car_count == 0
//     seq_error  high while an illegal sensor sequence is being flushed
module car_flow_counter #(
  parameter int unsigned CAPACITY = 15,
  parameter int unsigned COUNT_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sensor_a,
  input  logic               sensor_b,
  output logic [COUNT_W-1:0] car_count,
  output logic               car_enter,
  output logic               car_exit,
  output logic               overflow,
  output logic               underflow,
  output logic               full,
  output logic               empty,
  output logic               seq_error
);

  localparam logic [COUNT_W-1:0] CAP_C = COUNT_W'(CAPACITY);

  typedef enum logic [2:0] {
    IDLE,
    IN_A,
    IN_AB,
    IN_B,
    OUT_B,
    OUT_AB,
    OUT_A,
    ERR
  } state_t;

  state_t     state, state_nxt;
  logic       enter_evt, exit_evt;
  logic [1:0] s;

  assign s = {sensor_a, sensor_b};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    enter_evt = 1'b0;
    exit_evt  = 1'b0;
    unique case (state)
      IDLE: begin
        case (s)
          2'b10:   state_nxt = IN_A;
          2'b01:   state_nxt = OUT_B;
          2'b11:   state_nxt = ERR;
          default: state_nxt = IDLE;
        endcase
      end
      IN_A: begin
        case (s)
          2'b11:   state_nxt = IN_AB;
          2'b00:   state_nxt = IDLE;
          2'b10:   state_nxt = IN_A;
          default: state_nxt = ERR;
        endcase
      end
      IN_AB: begin
        case (s)
          2'b01:   state_nxt = IN_B;
          2'b10:   state_nxt = IN_A;
          2'b11:   state_nxt = IN_AB;
          default: state_nxt = ERR;
        endcase
      end
      IN_B: begin
        case (s)
          2'b00: begin
            state_nxt = IDLE;
            enter_evt = 1'b1;
          end
          2'b11:   state_nxt = IN_AB;
          2'b01:   state_nxt = IN_B;
          default: state_nxt = ERR;
        endcase
      end
      OUT_B: begin
        case (s)
          2'b11:   state_nxt = OUT_AB;
          2'b00:   state_nxt = IDLE;
          2'b01:   state_nxt = OUT_B;
          default: state_nxt = ERR;
        endcase
      end
      OUT_AB: begin
        case (s)
          2'b10:   state_nxt = OUT_A;
          2'b01:   state_nxt = OUT_B;
          2'b11:   state_nxt = OUT_AB;
          default: state_nxt = ERR;
        endcase
      end
      OUT_A: begin
        case (s)
          2'b00: begin
            state_nxt = IDLE;
            exit_evt  = 1'b1;
          end
          2'b11:   state_nxt = OUT_AB;
          2'b10:   state_nxt = OUT_A;
          default: state_nxt = ERR;
        endcase
      end
      ERR: begin
        if (s == 2'b00) state_nxt = IDLE;
      end
      default: state_nxt = ERR;
    endcase
  end

  // Count and pulses share one register stage so a pulse always coincides
  // with the cycle in which the new count is first visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      car_count <= '0;
      car_enter <= 1'b0;
      car_exit  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      car_enter <= 1'b0;
      car_exit  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      if (enter_evt) begin
        if (car_count < CAP_C) begin
          car_count <= car_count + 1'b1;
          car_enter <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (exit_evt) begin
        if (car_count != '0) begin
          car_count <= car_count - 1'b1;
          car_exit  <= 1'b1;
        end else begin
          underflow <= 1'b1;
        end
      end
    end
  end

  assign full      = (car_count == CAP_C);
  assign empty     = (car_count == '0);
  assign seq_error = (state == ERR);

endmodule

// File: tb/tb_car_flow_counter.sv
module tb_car_flow_counter;

  localparam int unsigned CAP = 15;
  localparam int unsigned CW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          sensor_a, sensor_b;
  logic [CW-1:0] car_count;
  logic          car_enter, car_exit, overflow, underflow, full, empty, seq_error;

  int tests = 0;
  int fails = 0;

  car_flow_counter #(.CAPACITY(CAP), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .sensor_a(sensor_a), .sensor_b(sensor_b),
    .car_count(car_count), .car_enter(car_enter), .car_exit(car_exit),
    .overflow(overflow), .underflow(underflow), .full(full), .empty(empty),
    .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cnt;
    logic en, ex, ov, un, err;
    int   idx;
  } exp_t;

  exp_t q[$];
  int   step_no = 0;

  // Reference model: a car is a position 0..3 along a path (entry or exit).
  // Each sensor pattern maps to a position on that path; a legal move changes
  // the position by at most one. Returning to 00 from position 3 completes the
  // path, from position 1 aborts it, from anywhere else is illegal.
  int   m_pos = 0;
  bit   m_exit_dir = 0;
  bit   m_err = 0;
  int   m_cnt = 0;

  function automatic int path_pos(input logic [1:0] s, input bit exit_dir);
    if (s == 2'b11) return 2;
    if (exit_dir) return (s == 2'b01) ? 1 : 3;
    return (s == 2'b10) ? 1 : 3;
  endfunction

  task automatic apply(input logic [1:0] s);
    exp_t e;
    int   np;
    bit   done;
    done = 0;
    e.en = 0; e.ex = 0; e.ov = 0; e.un = 0;
    sensor_a = s[1];
    sensor_b = s[0];
    if (m_err) begin
      if (s == 2'b00) m_err = 0;
    end else if (m_pos == 0) begin
      if (s == 2'b10)      begin m_exit_dir = 0; m_pos = 1; end
      else if (s == 2'b01) begin m_exit_dir = 1; m_pos = 1; end
      else if (s == 2'b11) m_err = 1;
    end else if (s == 2'b00) begin
      if (m_pos == 3) done = 1;
      else if (m_pos == 2) m_err = 1;
      m_pos = 0;
    end else begin
      np = path_pos(s, m_exit_dir);
      if (np - m_pos > 1 || m_pos - np > 1) begin
        m_err = 1;
        m_pos = 0;
      end else begin
        m_pos = np;
      end
    end
    if (done && !m_exit_dir) begin
      if (m_cnt < int'(CAP)) begin m_cnt++; e.en = 1; end
      else e.ov = 1;
    end else if (done && m_exit_dir) begin
      if (m_cnt > 0) begin m_cnt--; e.ex = 1; end
      else e.un = 1;
    end
    e.cnt = m_cnt;
    e.err = m_err;
    e.idx = step_no++;
    q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] s);
    @(negedge clk);
    apply(s);
  endtask

  task automatic hold(input logic [1:0] s, input int n);
    repeat (n) drive(s);
  endtask

  task automatic model_reset();
    m_pos = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every stimulus step yields one expected output snapshot,
  // observed just after the edge that samples it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check($sformatf("count[%0d]", e.idx), int'(car_count), e.cnt);
        check($sformatf("pulses[%0d]", e.idx),
              int'({car_enter, car_exit, overflow, underflow}),
              int'({e.en, e.ex, e.ov, e.un}));
        check($sformatf("seq_error[%0d]", e.idx), int'(seq_error), int'(e.err));
        check($sformatf("full_empty[%0d]", e.idx), int'({full, empty}),
              int'({e.cnt == int'(CAP), e.cnt == 0}));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] s, r;
    reset = 1'b1;
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_count", int'(car_count), 0);
    check("reset_flags", int'({full, empty, seq_error}), int'(3'b010));
    check("reset_pulses", int'({car_enter, car_exit, overflow, underflow}), 0);
    reset = 1'b0;
    model_reset();

    // 1: single entry; 2: single exit
    hold(2'b00, 3); hold(2'b10, 3); hold(2'b11, 3); hold(2'b01, 3); hold(2'b00, 3);
    hold(2'b01, 3); hold(2'b11, 3); hold(2'b10, 3); hold(2'b00, 3);

    // 3: aborted entries
    hold(2'b10, 2); hold(2'b00, 2);
    hold(2'b10, 2); hold(2'b11, 2); hold(2'b10, 2); hold(2'b00, 2);

    // 4: fill past capacity, then empty past zero
    for (int i = 0; i < 16; i++) begin
      drive(2'b10); drive(2'b11); drive(2'b01); drive(2'b00);
    end
    for (int i = 0; i < 16; i++) begin
      drive(2'b01); drive(2'b11); drive(2'b10); drive(2'b00);
    end

    // 5: illegal sequence, recovery, then a normal entry
    hold(2'b11, 2); hold(2'b10, 2); hold(2'b01, 2); hold(2'b00, 2);
    drive(2'b10); drive(2'b11); drive(2'b01); drive(2'b00); drive(2'b00);

    // 6: reset in the middle of an entry with count 5
    for (int i = 0; i < 4; i++) begin
      drive(2'b10); drive(2'b11); drive(2'b01); drive(2'b00);
    end
    drive(2'b10); drive(2'b11);
    @(negedge clk);
    check("pre_reset_count", int'(car_count), 5);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_count", int'(car_count), 0);
    check("async_reset_flags", int'({empty, seq_error}), int'(2'b10));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    apply(2'b01);
    hold(2'b00, 3);

    // Randomised sensor activity, mostly single-bit changes
    s = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      r = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 11))
        0, 1, 2, 3, 4, 5: s = s ^ (($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01);
        6:                s = s ^ 2'b11;
        7:                s = r;
        8:                s = 2'b00;
        default:          s = s;
      endcase
      drive(s);
    end
    hold(2'b00, 3);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
